// File: rtl/jtcontra_snd_cmdq.sv
`default_nettype none
// ============================================================================
// Module   : jtcontra_snd_cmdq
// Brief    : Main-to-sound CPU command FIFO with one-at-a-time IRQ sequencing
//            and a cen-paced quiet gap between successive commands.
// Revision : 1.0 - initial release
// ============================================================================
module jtcontra_snd_cmdq #(
    parameter int AW  = 2,
    parameter int GAP = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen,
    input  logic          main_wr,
    input  logic [7:0]    main_din,
    input  logic          snd_ack,
    output logic [7:0]    snd_latch,
    output logic          snd_irq,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam int            c_DEPTH   = 2**AW;
    localparam logic [AW:0]   c_FULL    = (AW+1)'(c_DEPTH);
    localparam logic [AW:0]   c_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
    localparam logic [7:0]    c_GAP     = 8'(GAP);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ASSERT = 2'd1;
    localparam logic [1:0] c_ST_WAIT   = 2'd2;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [7:0]    r_mem [c_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_nxt;
    logic [7:0]    r_cnt;
    logic [7:0]    r_latch;
    logic          r_irq;
    logic          r_full;
    logic          r_empty;
    logic          r_ovf;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then
    assign w_pop  = (r_state == c_ST_IDLE) && !r_empty;
    assign w_push = main_wr && (!r_full || w_pop);
    assign w_drop = main_wr && r_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + c_LVL_ONE;
            2'b01:   w_level_nxt = r_level - c_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_pop)                   w_state_nxt = c_ST_ASSERT;
            c_ST_ASSERT: if (snd_ack)                 w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:   if (cen && r_cnt <= 8'd1)    w_state_nxt = c_ST_IDLE;
            default:                                  w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Storage carries no reset: stale slots are never read while level is zero
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= main_din;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= c_ST_IDLE;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_cnt    <= 8'd0;
            r_latch  <= 8'd0;
            r_irq    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == c_FULL);
            r_empty <= (w_level_nxt == '0);
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_latch  <= r_mem[r_rd_ptr];
                r_irq    <= 1'b1;
            end
            if (r_state == c_ST_ASSERT && snd_ack) begin
                r_irq <= 1'b0;
                r_cnt <= c_GAP;
            end else if (r_state == c_ST_WAIT && cen && r_cnt != 8'd0) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_drop)       r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign snd_latch = r_latch;
    assign snd_irq   = r_irq;
    assign level     = r_level;
    assign full      = r_full;
    assign empty     = r_empty;
    assign overflow  = r_ovf;

endmodule
`default_nettype wire
